// File: rtl/master_start_pkg.sv
// Shared types for the queued burst synchroniser.
// Descriptor layout, FSM states and burst-type codes.
package master_start_pkg;

    localparam int TIME_W = 64;
    localparam int FREQ_W = 48;
    localparam int RATE_W = 32;
    localparam int N_W    = 16;
    localparam int INT_W  = 32;

    localparam logic [1:0] TYPE_NONCOH   = 2'd0;
    localparam logic [1:0] TYPE_COHERENT = 2'd1;

    typedef struct packed {
        logic [FREQ_W-1:0] freq;
        logic [FREQ_W-1:0] delta_freq;
        logic [RATE_W-1:0] delta_rate;
        logic [TIME_W-1:0] time_start;
        logic [N_W-1:0]    n_impuls;
        logic [1:0]        type_impulse;
        logic [INT_W-1:0]  ti;
        logic [INT_W-1:0]  tp;
        logic [INT_W-1:0]  tblank1;
        logic [INT_W-1:0]  tblank2;
    } burst_desc_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD,
        ST_REQ_HI,
        ST_REQ_LO,
        ST_ARM,
        ST_BLANK1,
        ST_TI,
        ST_BLANK2,
        ST_TP,
        ST_GAP
    } state_e;

    // Down-counter preload for a phase; a zero length still lasts one cycle.
    function automatic logic [INT_W-1:0] dur_m1(input logic [INT_W-1:0] d);
        return (d == '0) ? '0 : d - INT_W'(1);
    endfunction

endpackage

// File: rtl/burst_desc_fifo.sv
// Synchronous descriptor FIFO with level/full/empty.
// Simultaneous push and pop are both honoured, even when full.
module burst_desc_fifo
    import master_start_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          push,
    input  logic          pop,
    input  burst_desc_t   din,
    output burst_desc_t   dout,
    output logic [LW-1:0] level,
    output logic          full,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);

    burst_desc_t    mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_wr;
    logic           do_rd;

    assign empty = (level == '0);
    assign full  = (level == LW'(DEPTH));
    assign do_rd = pop && !empty;
    assign do_wr = push && (!full || do_rd);
    assign dout  = mem[rd_ptr];

    // Descriptor storage
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and fill level
    always_ff @(posedge clk) begin
        if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level <= level + LW'(do_wr) - LW'(do_rd);
        end
    end

endmodule

// File: rtl/master_start_queued.sv
// Queued burst synchroniser: system time, descriptor queue,
// DDS handshake and Tblank1/Ti/Tblank2/Tp window sequencing.
module master_start_queued
    import master_start_pkg::*;
#(
    parameter int TIME_W = master_start_pkg::TIME_W,
    parameter int FREQ_W = master_start_pkg::FREQ_W,
    parameter int RATE_W = master_start_pkg::RATE_W,
    parameter int N_W    = master_start_pkg::N_W,
    parameter int INT_W  = master_start_pkg::INT_W,
    parameter int DEPTH  = 4
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [TIME_W-1:0]     SYS_TIME,
    input  logic                  SYS_TIME_UPDATE,
    input  logic                  T1hz,
    input  logic                  WR_DATA,
    input  logic                  FLUSH,
    input  logic [FREQ_W-1:0]     MEM_DDS_freq,
    input  logic [FREQ_W-1:0]     MEM_DDS_delta_freq,
    input  logic [RATE_W-1:0]     MEM_DDS_delta_rate,
    input  logic [TIME_W-1:0]     MEM_TIME_START,
    input  logic [N_W-1:0]        MEM_N_impuls,
    input  logic [1:0]            MEM_TYPE_impulse,
    input  logic [INT_W-1:0]      MEM_Interval_Ti,
    input  logic [INT_W-1:0]      MEM_Interval_Tp,
    input  logic [INT_W-1:0]      MEM_Tblank1,
    input  logic [INT_W-1:0]      MEM_Tblank2,
    output logic [FREQ_W-1:0]     DDS_freq,
    output logic [FREQ_W-1:0]     DDS_delta_freq,
    output logic [RATE_W-1:0]     DDS_delta_rate,
    output logic                  REQ,
    input  logic                  ACK,
    output logic                  DDS_start,
    output logic                  En_Iz,
    output logic                  En_Pr,
    output logic                  SYS_TIME_UPDATE_OK,
    output logic [$clog2(DEPTH):0] Q_LEVEL,
    output logic                  Q_FULL,
    output logic                  OVF_ERR,
    output logic                  LATE_ERR
);

    localparam int LW = $clog2(DEPTH) + 1;

    logic [TIME_W-1:0] sys_cnt;
    logic              t1hz_q;
    logic              wr_q;
    logic              load_time;
    logic              push;
    logic              pop;
    logic              clr;
    logic              q_empty;
    burst_desc_t       din;
    burst_desc_t       head;

    state_e            state;
    logic [INT_W-1:0]  dcnt;
    logic [N_W-1:0]    n_left;
    logic              arm_first;
    logic              cur_coh;
    logic [TIME_W-1:0] cur_start;
    logic [INT_W-1:0]  cur_ti;
    logic [INT_W-1:0]  cur_tp;
    logic [INT_W-1:0]  cur_tb1;
    logic [INT_W-1:0]  cur_tb2;
    logic [TIME_W-1:0] t_next;
    logic [TIME_W-1:0] since_start;
    logic              is_late;

    assign clr       = RESET || FLUSH;
    assign load_time = SYS_TIME_UPDATE && !SYS_TIME_UPDATE_OK && T1hz && !t1hz_q;
    assign push      = WR_DATA && !wr_q;
    assign pop       = (state == ST_LOAD);

    // Start is matched one cycle ahead so DDS_start is high while time==start.
    assign t_next      = sys_cnt + TIME_W'(1);
    assign since_start = t_next - cur_start;
    assign is_late     = (since_start != '0) && !since_start[TIME_W-1];

    assign din = '{
        freq:         MEM_DDS_freq,
        delta_freq:   MEM_DDS_delta_freq,
        delta_rate:   MEM_DDS_delta_rate,
        time_start:   MEM_TIME_START,
        n_impuls:     MEM_N_impuls,
        type_impulse: MEM_TYPE_impulse,
        ti:           MEM_Interval_Ti,
        tp:           MEM_Interval_Tp,
        tblank1:      MEM_Tblank1,
        tblank2:      MEM_Tblank2
    };

    burst_desc_fifo #(
        .DEPTH (DEPTH),
        .LW    (LW)
    ) u_fifo (
        .clk   (CLK),
        .clr   (clr),
        .push  (push),
        .pop   (pop),
        .din   (din),
        .dout  (head),
        .level (Q_LEVEL),
        .full  (Q_FULL),
        .empty (q_empty)
    );

    // System time counter with armed 1 Hz preset; unaffected by FLUSH
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sys_cnt            <= '0;
            t1hz_q             <= 1'b0;
            SYS_TIME_UPDATE_OK <= 1'b0;
        end else begin
            t1hz_q  <= T1hz;
            sys_cnt <= load_time ? SYS_TIME : t_next;
            if (!SYS_TIME_UPDATE) begin
                SYS_TIME_UPDATE_OK <= 1'b0;
            end else if (load_time) begin
                SYS_TIME_UPDATE_OK <= 1'b1;
            end
        end
    end

    // Write-strobe edge detect and overflow pulse
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_q    <= 1'b0;
            OVF_ERR <= 1'b0;
        end else begin
            wr_q    <= WR_DATA;
            OVF_ERR <= !FLUSH && push && Q_FULL && !pop;
        end
    end

    // Burst sequencer: handshake, start wait and window phases
    always_ff @(posedge CLK) begin
        if (clr) begin
            state          <= ST_IDLE;
            dcnt           <= '0;
            n_left         <= '0;
            arm_first      <= 1'b0;
            cur_coh        <= 1'b0;
            cur_start      <= '0;
            cur_ti         <= '0;
            cur_tp         <= '0;
            cur_tb1        <= '0;
            cur_tb2        <= '0;
            DDS_freq       <= '0;
            DDS_delta_freq <= '0;
            DDS_delta_rate <= '0;
            REQ            <= 1'b0;
            DDS_start      <= 1'b0;
            En_Iz          <= 1'b0;
            En_Pr          <= 1'b0;
            LATE_ERR       <= 1'b0;
        end else begin
            LATE_ERR <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (!q_empty) begin
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (head.n_impuls == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        DDS_freq       <= head.freq;
                        DDS_delta_freq <= head.delta_freq;
                        DDS_delta_rate <= head.delta_rate;
                        cur_start      <= head.time_start;
                        n_left         <= head.n_impuls;
                        cur_coh        <= (head.type_impulse == TYPE_COHERENT);
                        cur_ti         <= head.ti;
                        cur_tp         <= head.tp;
                        cur_tb1        <= head.tblank1;
                        cur_tb2        <= head.tblank2;
                        REQ            <= 1'b1;
                        state          <= ST_REQ_HI;
                    end
                end
                ST_REQ_HI: begin
                    if (ACK) begin
                        REQ   <= 1'b0;
                        state <= ST_REQ_LO;
                    end
                end
                ST_REQ_LO: begin
                    if (!ACK) begin
                        arm_first <= 1'b1;
                        state     <= ST_ARM;
                    end
                end
                ST_ARM: begin
                    arm_first <= 1'b0;
                    if (t_next == cur_start) begin
                        DDS_start <= 1'b1;
                        dcnt      <= dur_m1(cur_tb1);
                        state     <= ST_BLANK1;
                    end else if (arm_first && is_late) begin
                        LATE_ERR <= 1'b1;
                        state    <= ST_IDLE;
                    end
                end
                ST_BLANK1: begin
                    if (dcnt == '0) begin
                        En_Iz <= 1'b1;
                        dcnt  <= dur_m1(cur_ti);
                        state <= ST_TI;
                    end else begin
                        dcnt <= dcnt - INT_W'(1);
                    end
                end
                ST_TI: begin
                    if (dcnt == '0) begin
                        En_Iz <= 1'b0;
                        dcnt  <= dur_m1(cur_tb2);
                        state <= ST_BLANK2;
                    end else begin
                        dcnt <= dcnt - INT_W'(1);
                    end
                end
                ST_BLANK2: begin
                    if (dcnt == '0) begin
                        En_Pr <= 1'b1;
                        dcnt  <= dur_m1(cur_tp);
                        state <= ST_TP;
                    end else begin
                        dcnt <= dcnt - INT_W'(1);
                    end
                end
                ST_TP: begin
                    if (dcnt == '0) begin
                        En_Pr  <= 1'b0;
                        n_left <= n_left - N_W'(1);
                        if (n_left == N_W'(1)) begin
                            DDS_start <= 1'b0;
                            state     <= ST_IDLE;
                        end else if (cur_coh) begin
                            dcnt  <= dur_m1(cur_tb1);
                            state <= ST_BLANK1;
                        end else begin
                            DDS_start <= 1'b0;
                            state     <= ST_GAP;
                        end
                    end else begin
                        dcnt <= dcnt - INT_W'(1);
                    end
                end
                ST_GAP: begin
                    DDS_start <= 1'b1;
                    dcnt      <= dur_m1(cur_tb1);
                    state     <= ST_BLANK1;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_master_start_queued.sv
// Scoreboard bench for master_start_queued: expected En_Iz rise
// times and DDS_freq loads are queued at push time and compared as they occur.
module tb_master_start_queued;
    import master_start_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [63:0] SYS_TIME = '0;
    logic        SYS_TIME_UPDATE = 1'b0;
    logic        T1hz = 1'b0;
    logic        WR_DATA = 1'b0;
    logic        FLUSH = 1'b0;
    logic [47:0] MEM_DDS_freq = '0;
    logic [47:0] MEM_DDS_delta_freq = '0;
    logic [31:0] MEM_DDS_delta_rate = '0;
    logic [63:0] MEM_TIME_START = '0;
    logic [15:0] MEM_N_impuls = '0;
    logic [1:0]  MEM_TYPE_impulse = '0;
    logic [31:0] MEM_Interval_Ti = '0;
    logic [31:0] MEM_Interval_Tp = '0;
    logic [31:0] MEM_Tblank1 = '0;
    logic [31:0] MEM_Tblank2 = '0;
    logic [47:0] DDS_freq;
    logic [47:0] DDS_delta_freq;
    logic [31:0] DDS_delta_rate;
    logic        REQ;
    logic        ACK = 1'b0;
    logic        DDS_start;
    logic        En_Iz;
    logic        En_Pr;
    logic        SYS_TIME_UPDATE_OK;
    logic [2:0]  Q_LEVEL;
    logic        Q_FULL;
    logic        OVF_ERR;
    logic        LATE_ERR;

    master_start_queued dut (
        .CLK(CLK), .RESET(RESET), .SYS_TIME(SYS_TIME),
        .SYS_TIME_UPDATE(SYS_TIME_UPDATE), .T1hz(T1hz),
        .WR_DATA(WR_DATA), .FLUSH(FLUSH),
        .MEM_DDS_freq(MEM_DDS_freq), .MEM_DDS_delta_freq(MEM_DDS_delta_freq),
        .MEM_DDS_delta_rate(MEM_DDS_delta_rate), .MEM_TIME_START(MEM_TIME_START),
        .MEM_N_impuls(MEM_N_impuls), .MEM_TYPE_impulse(MEM_TYPE_impulse),
        .MEM_Interval_Ti(MEM_Interval_Ti), .MEM_Interval_Tp(MEM_Interval_Tp),
        .MEM_Tblank1(MEM_Tblank1), .MEM_Tblank2(MEM_Tblank2),
        .DDS_freq(DDS_freq), .DDS_delta_freq(DDS_delta_freq),
        .DDS_delta_rate(DDS_delta_rate), .REQ(REQ), .ACK(ACK),
        .DDS_start(DDS_start), .En_Iz(En_Iz), .En_Pr(En_Pr),
        .SYS_TIME_UPDATE_OK(SYS_TIME_UPDATE_OK), .Q_LEVEL(Q_LEVEL),
        .Q_FULL(Q_FULL), .OVF_ERR(OVF_ERR), .LATE_ERR(LATE_ERR)
    );

    always #10 CLK = ~CLK;

    // DDS-side responder: ACK follows REQ after a short delay
    logic [2:0] ack_pipe = '0;
    always @(negedge CLK) begin
        ack_pipe = {ack_pipe[1:0], REQ};
        ACK = ack_pipe[2];
    end

    int passed = 0;
    int total = 0;
    int n_iz = 0, n_pr = 0, n_req = 0, n_gap1 = 0;
    int n_late = 0, n_ovf = 0, n_both = 0;
    longint ds_hi = 0;
    int low_run = 100;
    logic p_iz = 0, p_pr = 0, p_req = 0, p_ds = 0;
    logic [63:0] got_iz[$];
    logic [63:0] exp_iz[$];
    logic [47:0] got_freq[$];
    logic [47:0] exp_freq[$];

    task automatic tick();
        @(negedge CLK);
        if (En_Iz && !p_iz) begin
            n_iz++;
            got_iz.push_back(dut.sys_cnt);
        end
        if (En_Pr && !p_pr) n_pr++;
        if (REQ && !p_req) begin
            n_req++;
            got_freq.push_back(DDS_freq);
        end
        if (DDS_start) ds_hi++;
        if (En_Iz && En_Pr) n_both++;
        if (LATE_ERR) n_late++;
        if (OVF_ERR) n_ovf++;
        if (DDS_start && !p_ds && low_run == 1) n_gap1++;
        low_run = DDS_start ? 0 : low_run + 1;
        p_iz = En_Iz;
        p_pr = En_Pr;
        p_req = REQ;
        p_ds = DDS_start;
    endtask

    task automatic push_desc(input logic [47:0] f, input logic [63:0] st,
                             input logic [15:0] n, input logic [1:0] ty,
                             input logic [31:0] tb1, input logic [31:0] ti,
                             input logic [31:0] tb2, input logic [31:0] tp);
        MEM_DDS_freq = f;
        MEM_DDS_delta_freq = f >> 4;
        MEM_DDS_delta_rate = 32'h1234;
        MEM_TIME_START = st;
        MEM_N_impuls = n;
        MEM_TYPE_impulse = ty;
        MEM_Tblank1 = tb1;
        MEM_Interval_Ti = ti;
        MEM_Tblank2 = tb2;
        MEM_Interval_Tp = tp;
        WR_DATA = 1'b1;
        tick();
        WR_DATA = 1'b0;
        tick();
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            if (dut.state == ST_IDLE && Q_LEVEL == 0) ok = 1;
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        repeat (3) tick();
        RESET = 1'b0;
        tick();
        total++;
        if ({En_Iz, En_Pr, DDS_start, REQ, Q_FULL} !== 5'b0)
            $display("FAIL reset_outs: got %b want 00000",
                     {En_Iz, En_Pr, DDS_start, REQ, Q_FULL});
        else passed++;
        total++;
        if (Q_LEVEL !== 3'd0) $display("FAIL reset_level: got %0d want 0", Q_LEVEL);
        else passed++;
        total++;
        if (dut.sys_cnt !== 64'd1)
            $display("FAIL reset_time: got %h want 1", dut.sys_cnt);
        else passed++;
    endtask

    task automatic test_preset();
        SYS_TIME = 64'h100;
        SYS_TIME_UPDATE = 1'b1;
        tick();
        T1hz = 1'b1;
        tick();
        T1hz = 1'b0;
        total++;
        if (dut.sys_cnt !== 64'h100 || SYS_TIME_UPDATE_OK !== 1'b1)
            $display("FAIL preset_load: got %h ok=%b want 100 ok=1",
                     dut.sys_cnt, SYS_TIME_UPDATE_OK);
        else passed++;
        tick();
        total++;
        if (dut.sys_cnt !== 64'h101)
            $display("FAIL preset_next: got %h want 101", dut.sys_cnt);
        else passed++;
        T1hz = 1'b1;
        tick();
        T1hz = 1'b0;
        tick();
        total++;
        if (dut.sys_cnt !== 64'h103 || SYS_TIME_UPDATE_OK !== 1'b1)
            $display("FAIL preset_sticky: got %h ok=%b want 103 ok=1",
                     dut.sys_cnt, SYS_TIME_UPDATE_OK);
        else passed++;
        SYS_TIME_UPDATE = 1'b0;
        tick();
        total++;
        if (SYS_TIME_UPDATE_OK !== 1'b0)
            $display("FAIL preset_clear: got %b want 0", SYS_TIME_UPDATE_OK);
        else passed++;
    endtask

    task automatic test_coherent();
        int b_iz, b_pr, b_req, b_gap, b_both;
        longint b_hi;
        bit ok;
        logic [63:0] e, g;
        b_iz = n_iz; b_pr = n_pr; b_req = n_req;
        b_gap = n_gap1; b_both = n_both; b_hi = ds_hi;
        exp_freq.push_back(48'h0A_0000_0000);
        exp_iz.push_back(64'h12C0 + 64'h180);
        exp_iz.push_back(64'h12C0 + 64'h180 + 64'h3300);
        push_desc(48'h0A_0000_0000, 64'h12C0, 16'd2, TYPE_COHERENT,
                  32'h180, 32'h1800, 32'h180, 32'h1800);
        wait_idle(40000, ok);
        total++;
        if (!ok) $display("FAIL coh_timeout: got busy want idle");
        else passed++;
        total++;
        if (n_iz - b_iz !== 2 || n_pr - b_pr !== 2)
            $display("FAIL coh_pairs: got iz=%0d pr=%0d want 2/2",
                     n_iz - b_iz, n_pr - b_pr);
        else passed++;
        total++;
        if (ds_hi - b_hi !== 64'h6600 || n_gap1 - b_gap !== 0)
            $display("FAIL coh_start: got hi=%0h gaps=%0d want 6600/0",
                     ds_hi - b_hi, n_gap1 - b_gap);
        else passed++;
        total++;
        if (n_req - b_req !== 1 || n_both - b_both !== 0)
            $display("FAIL coh_req: got req=%0d both=%0d want 1/0",
                     n_req - b_req, n_both - b_both);
        else passed++;
        while (exp_iz.size() > 0) begin
            e = exp_iz.pop_front();
            total++;
            if (got_iz.size() == 0) $display("FAIL coh_iz: got none want %h", e);
            else begin
                g = got_iz.pop_front();
                if (g !== e) $display("FAIL coh_iz: got %h want %h", g, e);
                else passed++;
            end
        end
        total++;
        if (got_iz.size() != 0 || got_freq.size() != 1 || got_freq[0] !== exp_freq[0])
            $display("FAIL coh_freq: got n=%0d want single %h",
                     got_freq.size(), exp_freq[0]);
        else passed++;
        got_iz.delete(); got_freq.delete(); exp_freq.delete();
    endtask

    task automatic test_noncoherent();
        int b_req, b_gap, b_iz;
        longint b_hi;
        bit ok;
        logic [63:0] st, e, g;
        st = dut.sys_cnt + 64'h100;
        b_req = n_req; b_gap = n_gap1; b_iz = n_iz; b_hi = ds_hi;
        for (int k = 0; k < 4; k++)
            exp_iz.push_back(st + 64'h10 + 64'(k) * 64'h1021);
        push_desc(48'h0B_0000_0000, st, 16'd4, TYPE_NONCOH,
                  32'h10, 32'h800, 32'h10, 32'h800);
        wait_idle(20000, ok);
        total++;
        if (!ok) $display("FAIL nc_timeout: got busy want idle");
        else passed++;
        total++;
        if (n_gap1 - b_gap !== 3 || n_req - b_req !== 1 || n_iz - b_iz !== 4)
            $display("FAIL nc_counts: got gaps=%0d req=%0d iz=%0d want 3/1/4",
                     n_gap1 - b_gap, n_req - b_req, n_iz - b_iz);
        else passed++;
        total++;
        if (ds_hi - b_hi !== 64'h4080)
            $display("FAIL nc_high: got %0h want 4080", ds_hi - b_hi);
        else passed++;
        // type 2 behaves as non-coherent
        st = dut.sys_cnt + 64'h40;
        b_gap = n_gap1;
        exp_iz.push_back(st + 64'd2);
        exp_iz.push_back(st + 64'd13);
        push_desc(48'h0C_0000_0000, st, 16'd2, 2'd2, 32'd2, 32'd3, 32'd2, 32'd3);
        wait_idle(500, ok);
        total++;
        if (!ok || n_gap1 - b_gap !== 1)
            $display("FAIL type2_gap: got ok=%b gaps=%0d want 1/1", ok, n_gap1 - b_gap);
        else passed++;
        // zero durations last one cycle each
        st = dut.sys_cnt + 64'h40;
        b_gap = n_gap1; b_hi = ds_hi;
        exp_iz.push_back(st + 64'd1);
        exp_iz.push_back(st + 64'd5);
        push_desc(48'h0D_0000_0000, st, 16'd2, TYPE_COHERENT, 0, 0, 0, 0);
        wait_idle(500, ok);
        total++;
        if (!ok || ds_hi - b_hi !== 8 || n_gap1 - b_gap !== 0)
            $display("FAIL zero_dur: got ok=%b hi=%0d gaps=%0d want 1/8/0",
                     ok, ds_hi - b_hi, n_gap1 - b_gap);
        else passed++;
        while (exp_iz.size() > 0) begin
            e = exp_iz.pop_front();
            total++;
            if (got_iz.size() == 0) $display("FAIL nc_iz: got none want %h", e);
            else begin
                g = got_iz.pop_front();
                if (g !== e) $display("FAIL nc_iz: got %h want %h", g, e);
                else passed++;
            end
        end
        total++;
        if (got_iz.size() != 0) $display("FAIL nc_iz_extra: got %0d want 0", got_iz.size());
        else passed++;
        got_iz.delete(); got_freq.delete();
    endtask

    task automatic test_queue();
        int b_ovf, b_req;
        bit ok;
        logic [63:0] now;
        logic [47:0] e, g;
        now = dut.sys_cnt;
        b_ovf = n_ovf; b_req = n_req;
        exp_freq.push_back(48'h05_0000_0000);
        push_desc(48'h05_0000_0000, now + 64'h600, 16'd1, TYPE_COHERENT,
                  32'd4, 32'h20, 32'd4, 32'h20);
        for (int k = 1; k <= 4; k++) begin
            exp_freq.push_back(48'(k * 16) << 32);
            push_desc(48'(k * 16) << 32, now + 64'h700 + 64'(k) * 64'h100,
                      16'd1, TYPE_COHERENT, 32'd4, 32'h20, 32'd4, 32'h20);
        end
        total++;
        if (Q_FULL !== 1'b1 || Q_LEVEL !== 3'd4)
            $display("FAIL q_full: got full=%b lvl=%0d want 1/4", Q_FULL, Q_LEVEL);
        else passed++;
        push_desc(48'h50_0000_0000, now + 64'hF00, 16'd1, TYPE_COHERENT,
                  32'd4, 32'h20, 32'd4, 32'h20);
        total++;
        if (n_ovf - b_ovf !== 1 || Q_LEVEL !== 3'd4)
            $display("FAIL q_ovf: got ovf=%0d lvl=%0d want 1/4", n_ovf - b_ovf, Q_LEVEL);
        else passed++;
        wait_idle(10000, ok);
        total++;
        if (!ok || n_req - b_req !== 5)
            $display("FAIL q_drain: got ok=%b req=%0d want 1/5", ok, n_req - b_req);
        else passed++;
        while (exp_freq.size() > 0) begin
            e = exp_freq.pop_front();
            total++;
            if (got_freq.size() == 0) $display("FAIL q_order: got none want %h", e);
            else begin
                g = got_freq.pop_front();
                if (g !== e) $display("FAIL q_order: got %h want %h", g, e);
                else passed++;
            end
        end
        got_iz.delete(); got_freq.delete();
    endtask

    task automatic test_late_and_zero();
        int b_late, b_iz, b_req;
        bit ok;
        b_late = n_late; b_iz = n_iz; b_req = n_req;
        push_desc(48'h0E_0000_0000, dut.sys_cnt - 64'h10, 16'd1, TYPE_COHERENT,
                  32'd4, 32'd8, 32'd4, 32'd8);
        wait_idle(200, ok);
        total++;
        if (!ok || n_late - b_late !== 1 || n_iz - b_iz !== 0 || n_req - b_req !== 1)
            $display("FAIL late: got ok=%b late=%0d iz=%0d req=%0d want 1/1/0/1",
                     ok, n_late - b_late, n_iz - b_iz, n_req - b_req);
        else passed++;
        b_late = n_late; b_iz = n_iz; b_req = n_req;
        push_desc(48'h0F_0000_0000, dut.sys_cnt + 64'h40, 16'd0, TYPE_COHERENT,
                  32'd4, 32'd8, 32'd4, 32'd8);
        wait_idle(200, ok);
        repeat (100) tick();
        total++;
        if (!ok || n_late - b_late !== 0 || n_iz - b_iz !== 0 || n_req - b_req !== 0)
            $display("FAIL n_zero: got ok=%b late=%0d iz=%0d req=%0d want 1/0/0/0",
                     ok, n_late - b_late, n_iz - b_iz, n_req - b_req);
        else passed++;
        got_iz.delete(); got_freq.delete();
    endtask

    task automatic test_abort(input bit use_reset);
        bit ok;
        bit seen;
        logic [63:0] st, e, g;
        st = dut.sys_cnt + 64'h80;
        exp_iz.push_back(st + 64'd8);
        push_desc(48'h1A_0000_0000, st, 16'd1, TYPE_COHERENT,
                  32'd8, 32'h40, 32'd8, 32'h40);
        push_desc(48'h1B_0000_0000, st + 64'h2000, 16'd1, TYPE_COHERENT,
                  32'd8, 32'h40, 32'd8, 32'h40);
        seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            tick();
            if (En_Iz) seen = 1;
        end
        total++;
        if (!seen || Q_LEVEL !== 3'd1)
            $display("FAIL abort_pre: got seen=%b lvl=%0d want 1/1", seen, Q_LEVEL);
        else passed++;
        if (use_reset) RESET = 1'b1;
        else FLUSH = 1'b1;
        tick();
        total++;
        if (En_Iz !== 1'b0 || DDS_start !== 1'b0 || Q_LEVEL !== 3'd0)
            $display("FAIL abort_cut: got iz=%b ds=%b lvl=%0d want 0/0/0",
                     En_Iz, DDS_start, Q_LEVEL);
        else passed++;
        if (use_reset) begin
            total++;
            if (dut.sys_cnt !== 64'd0)
                $display("FAIL abort_time: got %h want 0", dut.sys_cnt);
            else passed++;
        end
        RESET = 1'b0;
        FLUSH = 1'b0;
        tick();
        st = use_reset ? 64'h200 : dut.sys_cnt + 64'h80;
        exp_iz.push_back(st + 64'd8);
        push_desc(48'h1C_0000_0000, st, 16'd1, TYPE_COHERENT,
                  32'd8, 32'h40, 32'd8, 32'h40);
        wait_idle(2000, ok);
        total++;
        if (!ok || got_freq.size() != 2 || got_freq[1] !== 48'h1C_0000_0000)
            $display("FAIL abort_after: got ok=%b loads=%0d want 1/2", ok, got_freq.size());
        else passed++;
        while (exp_iz.size() > 0) begin
            e = exp_iz.pop_front();
            total++;
            if (got_iz.size() == 0) $display("FAIL abort_iz: got none want %h", e);
            else begin
                g = got_iz.pop_front();
                if (g !== e) $display("FAIL abort_iz: got %h want %h", g, e);
                else passed++;
            end
        end
        got_iz.delete(); got_freq.delete();
    endtask

    initial begin
        test_reset();
        test_preset();
        test_coherent();
        test_noncoherent();
        test_queue();
        test_late_and_zero();
        test_abort(1'b0);
        test_abort(1'b1);
        total++;
        if (n_both !== 0) $display("FAIL exclusive: got %0d overlaps want 0", n_both);
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
